adc_conv_sequencer: RTL and testbench
=====================================

Name: adc_conv_sequencer

Overview:
Sequences the single shared ADC between the channel arbiter and the sample FIFO. It accepts one granted channel at a time and steers the ADC channel mux. After a settle time it issues the start pulse, waits for conversion-done with a timeout, then presents a timestamped sample to the FIFO writer over a valid/ready handshake. It sits between arbiter_inst and fifo_inst inside high_speed_daq_controller.

Parameters:
NUM_CHANNELS, 16, number of ADC input channels
ADC_WIDTH, 12, ADC result width
CHANNEL_WIDTH, 4, channel index width (clog2 NUM_CHANNELS)
TIMESTAMP_WIDTH, 32, free-running timestamp width
SETTLE_CYCLES, 2, mux settle cycles between accept and start pulse (0 allowed)
TIMEOUT_CYCLES, 64, max CONVERT cycles allowed without adc_conv_done

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global acquisition enable (CTRL reg bit 0)
req_valid  in  1  arbiter has a granted channel
req_channel  in  CHANNEL_WIDTH  granted channel index
req_ready  out  1  sequencer accepts the request this cycle
adc_start_conv  out  1  one-cycle start-of-conversion pulse
adc_channel_sel  out  CHANNEL_WIDTH  ADC mux select
adc_busy  in  1  ADC conversion in progress
adc_conv_done  in  1  one-cycle result-valid strobe
adc_data  in  ADC_WIDTH  ADC result
smp_valid  out  1  sample available to FIFO writer
smp_ready  in  1  FIFO writer accepts sample
smp_channel  out  CHANNEL_WIDTH  sample channel
smp_data  out  ADC_WIDTH  sample value
smp_timestamp  out  TIMESTAMP_WIDTH  timestamp latched at start pulse
seq_busy  out  1  state != IDLE
timeout_err  out  1  one-cycle pulse on conversion timeout
err_count  out  8  saturating timeout counter

Behaviour:
- Clock and reset: rst_n is asynchronous, active-low; clk is the clock. All outputs are registered except req_ready and seq_busy, which decode state.
- Reset values: all outputs are 0. The state is IDLE and the timestamp counter is 0.
- Timestamp: a free-running counter that increments every cycle and wraps modulo 2^TIMESTAMP_WIDTH.
- States: IDLE, SETTLE, START, CONVERT, OUTPUT, RECOVER.
- IDLE: req_ready = enable && !adc_busy. On req_valid && req_ready, latch req_channel into adc_channel_sel. Then go to SETTLE, or to START if SETTLE_CYCLES == 0.
- SETTLE: stays for exactly SETTLE_CYCLES cycles, then moves to START.
- START: adc_start_conv = 1 for this cycle only. The timestamp is latched. Next state is CONVERT with the timeout counter cleared.
- CONVERT: the counter increments every cycle.
  - If adc_conv_done is sampled: capture adc_data and go to OUTPUT.
  - Else, on the TIMEOUT_CYCLES-th cycle: pulse timeout_err the next cycle, increment err_count (saturates at 255), and go to RECOVER.
  - If conv_done and the timeout occur in the same cycle, conv_done wins.
- OUTPUT:
  - smp_valid = 1 starting the cycle after conv_done was sampled.
  - smp_channel, smp_data and smp_timestamp are held stable while smp_valid && !smp_ready.
  - On the handshake: go to IDLE, and smp_valid drops the next cycle.
- RECOVER: no sample is emitted. Wait until adc_busy == 0, then go to IDLE.
- adc_channel_sel holds the latched channel from accept until IDLE is re-entered, then holds its last value.
- adc_conv_done outside CONVERT is ignored.
- enable deasserted mid-transaction: the current conversion completes and its sample is emitted. enable only gates new accepts.
- req_valid is ignored outside IDLE. req_channel values >= NUM_CHANNELS are accepted as-is; the arbiter is responsible for range.
- Reset mid-operation: immediate return to IDLE and all outputs go to 0. err_count clears.
- Throughput: with smp_ready tied high, successive accepts are spaced SETTLE_CYCLES + conversion time + 3 cycles apart.

Decomposition:
- daq_pkg holds:
  - the seq_state_t enum (6 states);
  - the daq_sample_t struct {channel, data, timestamp} shared with the FIFO;
  - constants: default SETTLE_CYCLES, default TIMEOUT_CYCLES, ERR_COUNT_WIDTH = 8.
- No sub-module. The timestamp and timeout counters are inline.

Test Plan:
- Basic conversion. Stimulus: enable = 1, req_channel = 5 accepted at cycle T, ADC model with 20-cycle conversion returning 0xABC. Response: adc_channel_sel = 5 from T+1; adc_start_conv high only at T+3; smp_valid one cycle after conv_done with channel 5, data 0xABC, timestamp equal to the counter value at T+3.
- Backpressure. Stimulus: smp_ready held low for 10 cycles after smp_valid. Response: sample fields stable and req_ready = 0 throughout; IDLE one cycle after smp_ready rises.
- Timeout. Stimulus: ADC model never asserts conv_done and drops adc_busy after 100 cycles. Response: timeout_err pulses once, 64 cycles after START exit; err_count = 1; no smp_valid; req_ready returns only after adc_busy falls.
- Enable drop. Stimulus: enable deasserted during CONVERT. Response: sample still emitted; req_ready stays 0 while enable = 0 even with req_valid = 1.
- Saturation and reset. Stimulus: 300 forced timeouts, then rst_n pulsed low in CONVERT. Response: err_count = 255 before reset; all outputs 0 and state IDLE immediately on reset.
- Corner cases. Stimulus: SETTLE_CYCLES = 0 build, plus conv_done coincident with the final timeout cycle. Response: start pulse the cycle after accept; sample emitted and no timeout_err.

Source files
------------

// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ acquisition path
// (sequencer and sample FIFO).
package daq_pkg;

  // Default timing for the ADC sequencer.
  localparam int DEFAULT_SETTLE_CYCLES  = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int ERR_COUNT_WIDTH        = 8;

  // Default field widths of a sample word.
  localparam int SMP_CHANNEL_WIDTH = 4;
  localparam int SMP_DATA_WIDTH    = 12;
  localparam int SMP_TS_WIDTH      = 32;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_START   = 3'd2,
    ST_CONVERT = 3'd3,
    ST_OUTPUT  = 3'd4,
    ST_RECOVER = 3'd5
  } seq_state_t;

  // Sample word as written into the FIFO.
  typedef struct packed {
    logic [SMP_CHANNEL_WIDTH-1:0] channel;
    logic [SMP_DATA_WIDTH-1:0]    data;
    logic [SMP_TS_WIDTH-1:0]      timestamp;
  } daq_sample_t;

endpackage

// File: rtl/adc_conv_sequencer.sv
// ADC conversion sequencer: accepts one granted channel, steers the ADC mux,
// waits a settle time, pulses start-of-conversion, waits for done (with
// timeout) and hands a timestamped sample to the FIFO writer.
module adc_conv_sequencer
  import daq_pkg::*;
#(
  parameter int NUM_CHANNELS    = 16,
  parameter int ADC_WIDTH       = 12,
  parameter int CHANNEL_WIDTH   = 4,
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       req_valid,
  input  logic [CHANNEL_WIDTH-1:0]   req_channel,
  output logic                       req_ready,
  output logic                       adc_start_conv,
  output logic [CHANNEL_WIDTH-1:0]   adc_channel_sel,
  input  logic                       adc_busy,
  input  logic                       adc_conv_done,
  input  logic [ADC_WIDTH-1:0]       adc_data,
  output logic                       smp_valid,
  input  logic                       smp_ready,
  output logic [CHANNEL_WIDTH-1:0]   smp_channel,
  output logic [ADC_WIDTH-1:0]       smp_data,
  output logic [TIMESTAMP_WIDTH-1:0] smp_timestamp,
  output logic                       seq_busy,
  output logic                       timeout_err,
  output logic [ERR_COUNT_WIDTH-1:0] err_count
);

  // Counter widths; both counters count 0 .. N-1.
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_t                 state_q, state_d;
  logic [TIMESTAMP_WIDTH-1:0] ts_cnt_q;
  logic [TIMESTAMP_WIDTH-1:0] start_ts_q;
  logic [SET_W-1:0]           settle_cnt_q;
  logic [TMO_W-1:0]           tmo_cnt_q;
  logic [CHANNEL_WIDTH-1:0]   chan_sel_q;
  logic                       start_conv_q;
  logic                       smp_valid_q;
  logic [CHANNEL_WIDTH-1:0]   smp_channel_q;
  logic [ADC_WIDTH-1:0]       smp_data_q;
  logic [TIMESTAMP_WIDTH-1:0] smp_ts_q;
  logic                       timeout_err_q;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q;

  logic accept;
  logic conv_hit;
  logic tmo_hit;
  logic idle_ready;

  // A new request can only be taken while idle, enabled and the ADC is free.
  assign idle_ready = (state_q == ST_IDLE) && enable && !adc_busy;

  // Next-state decode; conv_done takes priority over a coincident timeout.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    conv_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && idle_ready) begin
          accept  = 1'b1;
          state_d = (SETTLE_CYCLES == 0) ? ST_START : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SET_LAST) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (adc_conv_done) begin
          conv_hit = 1'b1;
          state_d  = ST_OUTPUT;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_RECOVER;
        end
      end
      ST_OUTPUT: begin
        if (smp_ready) state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (!adc_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: timestamp, settle/timeout counters, registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q      <= '0;
      start_ts_q    <= '0;
      settle_cnt_q  <= '0;
      tmo_cnt_q     <= '0;
      chan_sel_q    <= '0;
      start_conv_q  <= 1'b0;
      smp_valid_q   <= 1'b0;
      smp_channel_q <= '0;
      smp_data_q    <= '0;
      smp_ts_q      <= '0;
      timeout_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      ts_cnt_q      <= ts_cnt_q + 1'b1;
      // Start pulse and sample-valid track the state they belong to.
      start_conv_q  <= (state_d == ST_START);
      smp_valid_q   <= (state_d == ST_OUTPUT);
      timeout_err_q <= tmo_hit;

      if (accept) chan_sel_q <= req_channel;

      settle_cnt_q <= (state_q == ST_SETTLE) ? settle_cnt_q + 1'b1 : '0;

      if (state_q == ST_START) begin
        start_ts_q <= ts_cnt_q;
        tmo_cnt_q  <= '0;
      end else if (state_q == ST_CONVERT) begin
        tmo_cnt_q  <= tmo_cnt_q + 1'b1;
      end

      // Sample fields only change on capture, so they hold under backpressure.
      if (conv_hit) begin
        smp_channel_q <= chan_sel_q;
        smp_data_q    <= adc_data;
        smp_ts_q      <= start_ts_q;
      end

      if (tmo_hit && (err_count_q != {ERR_COUNT_WIDTH{1'b1}})) begin
        err_count_q <= err_count_q + 1'b1;
      end
    end
  end

  assign req_ready       = idle_ready;
  assign seq_busy        = (state_q != ST_IDLE);
  assign adc_start_conv  = start_conv_q;
  assign adc_channel_sel = chan_sel_q;
  assign smp_valid       = smp_valid_q;
  assign smp_channel     = smp_channel_q;
  assign smp_data        = smp_data_q;
  assign smp_timestamp   = smp_ts_q;
  assign timeout_err     = timeout_err_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer: default build (settle 2) driven by a
// behavioural ADC model, plus a settle-0 build driven by hand.
module tb_adc_conv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-parameter instance.
  logic        enable = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_channel = '0;
  logic        req_ready;
  logic        adc_start_conv;
  logic [3:0]  adc_channel_sel;
  logic        adc_busy = 1'b0;
  logic        adc_conv_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        smp_valid;
  logic        smp_ready = 1'b0;
  logic [3:0]  smp_channel;
  logic [11:0] smp_data;
  logic [31:0] smp_timestamp;
  logic        seq_busy;
  logic        timeout_err;
  logic [7:0]  err_count;

  // SETTLE_CYCLES = 0 instance.
  logic        z_enable = 1'b0;
  logic        z_req_valid = 1'b0;
  logic [3:0]  z_req_channel = '0;
  logic        z_req_ready;
  logic        z_adc_start_conv;
  logic [3:0]  z_adc_channel_sel;
  logic        z_adc_busy = 1'b0;
  logic        z_adc_conv_done = 1'b0;
  logic [11:0] z_adc_data = '0;
  logic        z_smp_valid;
  logic        z_smp_ready = 1'b0;
  logic [3:0]  z_smp_channel;
  logic [11:0] z_smp_data;
  logic [31:0] z_smp_timestamp;
  logic        z_seq_busy;
  logic        z_timeout_err;
  logic [7:0]  z_err_count;

  adc_conv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_channel(req_channel), .req_ready(req_ready),
    .adc_start_conv(adc_start_conv), .adc_channel_sel(adc_channel_sel),
    .adc_busy(adc_busy), .adc_conv_done(adc_conv_done), .adc_data(adc_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_channel(smp_channel),
    .smp_data(smp_data), .smp_timestamp(smp_timestamp),
    .seq_busy(seq_busy), .timeout_err(timeout_err), .err_count(err_count)
  );

  adc_conv_sequencer #(.SETTLE_CYCLES(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .enable(z_enable),
    .req_valid(z_req_valid), .req_channel(z_req_channel), .req_ready(z_req_ready),
    .adc_start_conv(z_adc_start_conv), .adc_channel_sel(z_adc_channel_sel),
    .adc_busy(z_adc_busy), .adc_conv_done(z_adc_conv_done), .adc_data(z_adc_data),
    .smp_valid(z_smp_valid), .smp_ready(z_smp_ready), .smp_channel(z_smp_channel),
    .smp_data(z_smp_data), .smp_timestamp(z_smp_timestamp),
    .seq_busy(z_seq_busy), .timeout_err(z_timeout_err), .err_count(z_err_count)
  );

  always #5 clk = ~clk;

  // Reference timestamp: counts clock edges since reset release.
  logic [31:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1;
  end

  // Behavioural ADC: on a start pulse goes busy for model_len cycles, then
  // strobes done with model_data (unless model_hang, which only drops busy).
  int          model_len = 20;
  bit          model_hang = 1'b0;
  logic [11:0] model_data = '0;
  int          model_cnt = 0;
  always begin
    @(posedge clk);
    #1;
    adc_conv_done = 1'b0;
    if (!rst_n) begin
      adc_busy  = 1'b0;
      model_cnt = 0;
    end else if (adc_start_conv) begin
      adc_busy  = 1'b1;
      model_cnt = model_len;
    end else if (adc_busy) begin
      model_cnt = model_cnt - 1;
      if (model_cnt == 0) begin
        adc_busy = 1'b0;
        if (!model_hang) begin
          adc_conv_done = 1'b1;
          adc_data      = model_data;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for smp_valid on the default instance; k = cycles waited.
  task automatic wait_smp(input int lim, output int k);
    k = 0;
    while (!smp_valid && k < lim) begin
      @(negedge clk);
      k++;
    end
  endtask

  // One complete transaction on the default instance, bounded at each step.
  task automatic run_txn(input logic [3:0] ch);
    int k;
    k = 0;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    chk("txn_ready", 32'(req_ready), 1);
    req_channel = ch;
    req_valid   = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (seq_busy && k < 300) begin @(negedge clk); k++; end
    chk("txn_idle", 32'(seq_busy), 0);
  endtask

  initial begin
    int          k;
    int          tn;
    int          t_at;
    int          v_at;
    int          r_at;
    int          vseen;
    logic [31:0] exp_ts;
    logic [11:0] got_data;

    // ---------------- reset values ----------------
    tick(2);
    chk("rst_sel",     32'(adc_channel_sel), 0);
    chk("rst_start",   32'(adc_start_conv), 0);
    chk("rst_valid",   32'(smp_valid), 0);
    chk("rst_ts",      smp_timestamp, 0);
    chk("rst_busy",    32'(seq_busy), 0);
    chk("rst_tmo",     32'(timeout_err), 0);
    chk("rst_errcnt",  32'(err_count), 0);
    chk("rst_z_valid", 32'(z_smp_valid), 0);
    rst_n = 1'b1;
    tick(2);

    // ---------------- basic conversion ----------------
    enable = 1'b1; smp_ready = 1'b1;
    model_len = 20; model_hang = 1'b0; model_data = 12'hABC;
    req_channel = 4'd5; req_valid = 1'b1;
    #1;
    chk("t1_req_ready", 32'(req_ready), 1);
    exp_ts = tb_ts + 3;
    @(negedge clk); req_valid = 1'b0;                  // T+1
    chk("t1_sel",      32'(adc_channel_sel), 5);
    chk("t1_seq_busy", 32'(seq_busy), 1);
    chk("t1_start_t1", 32'(adc_start_conv), 0);
    @(negedge clk);                                    // T+2
    chk("t1_start_t2", 32'(adc_start_conv), 0);
    @(negedge clk);                                    // T+3
    chk("t1_start_t3", 32'(adc_start_conv), 1);
    @(negedge clk);                                    // T+4
    chk("t1_start_t4", 32'(adc_start_conv), 0);
    wait_smp(60, k);
    chk("t1_valid",   32'(smp_valid), 1);
    chk("t1_latency", k, 20);
    chk("t1_ch",      32'(smp_channel), 5);
    chk("t1_data",    32'(smp_data), 'hABC);
    chk("t1_ts",      smp_timestamp, exp_ts);
    @(negedge clk);
    chk("t1_valid_drop", 32'(smp_valid), 0);
    chk("t1_idle",       32'(seq_busy), 0);
    $display("txn basic: ch=%0d data=0x%0h ts=%0d", smp_channel, smp_data, smp_timestamp);

    // ---------------- backpressure ----------------
    smp_ready = 1'b0;
    model_len = 5; model_data = 12'h123;
    req_channel = 4'd9; req_valid = 1'b1;
    #1;
    chk("t2_req_ready", 32'(req_ready), 1);
    exp_ts = tb_ts + 3;
    @(negedge clk); req_valid = 1'b0;
    wait_smp(40, k);
    chk("t2_valid", 32'(smp_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", 32'(smp_valid), 1);
      chk("t2_hold_ch",    32'(smp_channel), 9);
      chk("t2_hold_data",  32'(smp_data), 'h123);
      chk("t2_hold_ts",    smp_timestamp, exp_ts);
      chk("t2_hold_rdy",   32'(req_ready), 0);
    end
    smp_ready = 1'b1;
    @(negedge clk);
    chk("t2_idle",      32'(seq_busy), 0);
    chk("t2_valid_off", 32'(smp_valid), 0);
    chk("t2_req_ready", 32'(req_ready), 1);
    $display("txn backpressure: ch=9 data=0x123 released after 10 stalled cycles");

    // ---------------- timeout ----------------
    model_hang = 1'b1; model_len = 100;
    req_channel = 4'd3; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;                  // T+1
    tick(2);                                           // T+3 = START
    chk("t3_start", 32'(adc_start_conv), 1);
    tn = 0; t_at = 0; r_at = 0; vseen = 0;
    for (int off = 1; off <= 130; off++) begin
      @(negedge clk);
      if (timeout_err) begin tn++; t_at = off; end
      if (smp_valid) vseen++;
      if (req_ready && r_at == 0) r_at = off;
    end
    chk("t3_tmo_count", tn, 1);
    chk("t3_tmo_at",    t_at, 65);
    chk("t3_no_valid",  vseen, 0);
    chk("t3_rdy_at",    r_at, 101);
    chk("t3_errcnt",    32'(err_count), 1);
    $display("txn timeout: ch=3 err_count=%0d", err_count);
    model_hang = 1'b0;

    // ---------------- enable drop ----------------
    model_len = 10; model_data = 12'h5A5;
    req_channel = 4'd7; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    tick(4);                                           // inside CONVERT
    enable = 1'b0; req_valid = 1'b1;
    wait_smp(40, k);
    chk("t4_valid", 32'(smp_valid), 1);
    chk("t4_ch",    32'(smp_channel), 7);
    chk("t4_data",  32'(smp_data), 'h5A5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_rdy_gated", 32'(req_ready), 0);
      chk("t4_no_accept", 32'(seq_busy), 0);
    end
    req_valid = 1'b0; enable = 1'b1;
    #1;
    chk("t4_rdy_back", 32'(req_ready), 1);
    $display("txn enable-drop: ch=7 data=0x5a5 emitted with enable low");

    // ---------------- done coincident with last timeout cycle ----------------
    @(negedge clk);
    model_len = 64; model_data = 12'h777;
    req_channel = 4'd2; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    tick(2);                                           // START
    tn = 0; v_at = 0; got_data = '0;
    for (int off = 1; off <= 80; off++) begin
      @(negedge clk);
      if (timeout_err) tn++;
      if (smp_valid && v_at == 0) begin v_at = off; got_data = smp_data; end
    end
    chk("t5_no_tmo",  tn, 0);
    chk("t5_v_at",    v_at, 65);
    chk("t5_data",    32'(got_data), 'h777);
    chk("t5_errcnt",  32'(err_count), 1);
    $display("txn coincident: ch=2 data=0x%0h timeouts=%0d", got_data, tn);

    // ---------------- SETTLE_CYCLES = 0 build ----------------
    z_enable = 1'b1; z_smp_ready = 1'b1;
    z_adc_conv_done = 1'b1; z_adc_data = 12'hFFF;      // stray done while idle
    @(negedge clk); z_adc_conv_done = 1'b0;
    @(negedge clk);
    chk("t6_stray_valid", 32'(z_smp_valid), 0);
    chk("t6_stray_busy",  32'(z_seq_busy), 0);
    z_req_channel = 4'd11; z_req_valid = 1'b1;
    #1;
    chk("t6_req_ready", 32'(z_req_ready), 1);
    exp_ts = tb_ts + 1;
    @(negedge clk); z_req_valid = 1'b0;                // T+1
    chk("t6_start_t1", 32'(z_adc_start_conv), 1);
    chk("t6_sel",      32'(z_adc_channel_sel), 11);
    @(negedge clk);                                    // T+2, CONVERT
    chk("t6_start_t2", 32'(z_adc_start_conv), 0);
    z_adc_conv_done = 1'b1; z_adc_data = 12'h3C3;
    @(negedge clk); z_adc_conv_done = 1'b0;            // T+3
    chk("t6_valid", 32'(z_smp_valid), 1);
    chk("t6_ch",    32'(z_smp_channel), 11);
    chk("t6_data",  32'(z_smp_data), 'h3C3);
    chk("t6_ts",    z_smp_timestamp, exp_ts);
    @(negedge clk);
    chk("t6_idle",  32'(z_seq_busy), 0);
    $display("txn settle0: ch=11 data=0x%0h", z_smp_data);

    // ---------------- err_count saturation ----------------
    model_hang = 1'b1; model_len = 70;
    for (int i = 0; i < 300; i++) run_txn(4'(i));
    chk("t7_errcnt_sat", 32'(err_count), 255);
    $display("txn saturation: 300 timeouts, err_count=%0d", err_count);

    // ---------------- reset in CONVERT ----------------
    model_hang = 1'b0; model_len = 20; model_data = 12'h456;
    req_channel = 4'd6; req_valid = 1'b1;
    @(negedge clk); req_valid = 1'b0;
    tick(5);                                           // CONVERT
    chk("t8_pre_busy", 32'(seq_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_busy",   32'(seq_busy), 0);
    chk("t8_sel",    32'(adc_channel_sel), 0);
    chk("t8_start",  32'(adc_start_conv), 0);
    chk("t8_valid",  32'(smp_valid), 0);
    chk("t8_ch",     32'(smp_channel), 0);
    chk("t8_data",   32'(smp_data), 0);
    chk("t8_ts",     smp_timestamp, 0);
    chk("t8_tmo",    32'(timeout_err), 0);
    chk("t8_errcnt", 32'(err_count), 0);
    $display("txn reset: outputs cleared mid-conversion");
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
